// File: rtl/matmul_sched_pkg.sv
// Shared types for the matmul job scheduler: FSM encoding, default widths, job descriptor.
package matmul_sched_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_TAG_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_REPORT    = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] base_a;
    logic [DEF_ADDR_W-1:0] base_b;
    logic [DEF_ADDR_W-1:0] base_c;
    logic [DEF_TAG_W-1:0]  tag;
  } job_desc_t;

endpackage

// File: rtl/matmul_sched_fifo.sv
// Descriptor FIFO: registered level/full/empty, head data read combinationally.
// Push is ignored when full and pop when empty; no same-cycle bypass.
module matmul_sched_fifo #(
  parameter int DATA_W = 34,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_dat_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] pop_dat_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              push_ok, pop_ok;

  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign pop_dat_o = mem_q[rd_ptr_q];
  assign push_ok   = push_i && !full_o;
  assign pop_ok    = pop_i && !empty_o;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Queues job descriptors and runs them one at a time on the matmul engine; push-to-kick is 2 cycles.
// MATMUL_SCHED_TIMEOUT_EN adds a per-job watchdog that reports done_error after TIMEOUT_CYC cycles.
module matmul_job_scheduler
  import matmul_sched_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DEPTH       = 4,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_valid,
  output logic                     job_ready,
  input  logic [ADDR_W-1:0]        job_base_a,
  input  logic [ADDR_W-1:0]        job_base_b,
  input  logic [ADDR_W-1:0]        job_base_c,
  input  logic [TAG_W-1:0]         job_tag,
  output logic                     eng_kick_start,
  input  logic                     eng_ready,
  output logic [ADDR_W-1:0]        eng_base_a,
  output logic [ADDR_W-1:0]        eng_base_b,
  output logic [ADDR_W-1:0]        eng_base_c,
  output logic                     done_valid,
  input  logic                     done_ready,
  output logic [TAG_W-1:0]         done_tag,
  output logic                     done_error,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   queue_level
);

  typedef struct packed {
    logic [ADDR_W-1:0] base_a;
    logic [ADDR_W-1:0] base_b;
    logic [ADDR_W-1:0] base_c;
    logic [TAG_W-1:0]  tag;
  } job_t;

  sched_state_e state_q, state_d;
  job_t         job_q, job_d;
  job_t         fifo_head, fifo_in;
  logic         fifo_full, fifo_empty, fifo_pop;
  logic         timeout_hit;

  assign fifo_in = '{base_a: job_base_a, base_b: job_base_b, base_c: job_base_c, tag: job_tag};

  matmul_sched_fifo #(
    .DATA_W ($bits(job_t)),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (job_valid),
    .push_dat_i (fifo_in),
    .pop_i      (fifo_pop),
    .pop_dat_o  (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .level_o    (queue_level)
  );

`ifdef MATMUL_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             in_wait;

  assign in_wait     = (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_DONE);
  // cnt_q equals cycles since the kick, so REPORT lands TIMEOUT_CYC cycles after LAUNCH.
  assign timeout_hit = in_wait && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    if (state_q == ST_LAUNCH) cnt_d = CNT_W'(1);
    else if (in_wait)         cnt_d = cnt_q + CNT_W'(1);
    if (in_wait)                                 err_d = timeout_hit;
    else if (state_q == ST_REPORT && done_ready) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign done_error = err_q;
`else
  logic unused_timeout_cyc;

  // Parameter kept so both builds share one instantiation footprint.
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign done_error         = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    job_d    = job_q;
    fifo_pop = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && eng_ready) begin
          fifo_pop = 1'b1;
          job_d    = fifo_head;
          state_d  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (timeout_hit)     state_d = ST_REPORT;
        else if (!eng_ready) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (timeout_hit || eng_ready) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      job_q   <= '0;
    end else begin
      state_q <= state_d;
      job_q   <= job_d;
    end
  end

  assign job_ready      = !fifo_full;
  assign eng_kick_start = (state_q == ST_LAUNCH);
  assign eng_base_a     = job_q.base_a;
  assign eng_base_b     = job_q.base_b;
  assign eng_base_c     = job_q.base_c;
  assign done_valid     = (state_q == ST_REPORT);
  assign done_tag       = job_q.tag;
  assign busy           = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed bench for matmul_job_scheduler with a behavioural engine model (busy 60 cycles per kick).
module tb_matmul_job_scheduler;
  import matmul_sched_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       job_valid, job_ready;
  logic [9:0] job_base_a, job_base_b, job_base_c;
  logic [3:0] job_tag;
  logic       eng_kick_start;
  logic       eng_ready = 1'b1;
  logic [9:0] eng_base_a, eng_base_b, eng_base_c;
  logic       done_valid, done_ready, done_error, busy;
  logic [3:0] done_tag;
  logic [2:0] queue_level;

  int n_cmp = 0;
  int n_bad = 0;

  matmul_job_scheduler #(
    .ADDR_W(10), .DEPTH(4), .TAG_W(4), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_base_a(job_base_a), .job_base_b(job_base_b), .job_base_c(job_base_c), .job_tag(job_tag),
    .eng_kick_start(eng_kick_start), .eng_ready(eng_ready),
    .eng_base_a(eng_base_a), .eng_base_b(eng_base_b), .eng_base_c(eng_base_c),
    .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag), .done_error(done_error),
    .busy(busy), .queue_level(queue_level)
  );

  always #5 clk = ~clk;

  // Engine model: drops ready the cycle after a kick, stays busy eng_busy_len cycles.
  int eng_cnt      = 0;
  int eng_busy_len = 60;
  bit eng_pend     = 1'b0;
  bit eng_stall    = 1'b0;
  bit eng_hang     = 1'b0;

  always @(negedge clk) begin
    if (eng_pend) begin
      if (!eng_hang) eng_cnt = eng_busy_len;
    end else if (eng_cnt > 0) begin
      eng_cnt = eng_cnt - 1;
    end
    eng_pend  = eng_kick_start;
    eng_ready = !eng_stall && (eng_cnt == 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic job_desc_t mk(input logic [3:0] tag, input logic [9:0] a,
                                   input logic [9:0] b, input logic [9:0] c);
    job_desc_t d;
    d.base_a = a;
    d.base_b = b;
    d.base_c = c;
    d.tag    = tag;
    return d;
  endfunction

  task automatic drive(input job_desc_t d);
    job_base_a = d.base_a;
    job_base_b = d.base_b;
    job_base_c = d.base_c;
    job_tag    = d.tag;
  endtask

  task automatic push_job(input job_desc_t d);
    int n;
    drive(d);
    job_valid = 1'b1;
    n = 0;
    while (!job_ready && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) chk("push_wait_timeout", 32'(n), 0);
    tick();
    job_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done_valid && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "global watchdog");
  end

  initial begin
    int n, got, kicks, seen;
    bit acc;

    rst = 1'b1; job_valid = 1'b0; done_ready = 1'b0;
    drive(mk(4'h0, 10'h0, 10'h0, 10'h0));
    repeat (3) tick();

    chk("rst_job_ready", job_ready, 1);
    chk("rst_queue_level", queue_level, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_kick", eng_kick_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_base_a", eng_base_a, 0);
    chk("rst_eng_base_b", eng_base_b, 0);
    chk("rst_eng_base_c", eng_base_c, 0);
    chk("rst_done_tag", done_tag, 0);
    chk("rst_done_error", done_error, 0);
    rst = 1'b0;
    tick();

    // Single job: kick two cycles after the push edge, done 62 cycles after kick.
    push_job(mk(4'd3, 10'h000, 10'h100, 10'h200));
    chk("t1_level_after_push", queue_level, 1);
    chk("t1_no_kick_yet", eng_kick_start, 0);
    chk("t1_busy", busy, 1);
    tick();
    chk("t1_kick", eng_kick_start, 1);
    chk("t1_base_a", eng_base_a, 10'h000);
    chk("t1_base_b", eng_base_b, 10'h100);
    chk("t1_base_c", eng_base_c, 10'h200);
    chk("t1_level_after_pop", queue_level, 0);
    tick();
    chk("t1_kick_one_cycle", eng_kick_start, 0);
    wait_done(200, n);
    chk("t1_done_valid", done_valid, 1);
    chk("t1_done_latency", 32'(n), 61);
    chk("t1_done_tag", done_tag, 3);
    chk("t1_done_error", done_error, 0);
    chk("t1_base_stable", eng_base_b, 10'h100);
    done_ready = 1'b1;
    tick();
    chk("t1_done_cleared", done_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // Five jobs into a 4-deep FIFO with the engine stalled.
    eng_stall = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(mk(4'(i), 10'(i * 16), 10'(i * 16 + 1), 10'(i * 16 + 2)));
      job_valid = 1'b1;
      tick();
    end
    chk("t2_full_ready", job_ready, 0);
    chk("t2_full_level", queue_level, 4);
    drive(mk(4'd4, 10'd64, 10'd65, 10'd66));
    tick();
    chk("t2_fifth_held_level", queue_level, 4);
    chk("t2_fifth_held_ready", job_ready, 0);
    chk("t2_stalled_no_kick", eng_kick_start, 0);
    eng_stall = 1'b0;
    got = 0; kicks = 0; n = 0;
    while (got < 5 && n < 3000) begin
      if (eng_kick_start) begin
        chk("t2_kick_base_a", eng_base_a, 32'(kicks * 16));
        chk("t2_kick_base_c", eng_base_c, 32'(kicks * 16 + 2));
        kicks++;
      end
      if (done_valid) begin
        chk("t2_done_tag_order", done_tag, 32'(got));
        chk("t2_done_error", done_error, 0);
        got++;
      end
      acc = job_valid && job_ready;
      tick();
      n++;
      if (acc) job_valid = 1'b0;
    end
    chk("t2_done_count", 32'(got), 5);
    chk("t2_kick_count", 32'(kicks), 5);
    chk("t2_drained_level", queue_level, 0);
    chk("t2_drained_busy", busy, 0);

    // REPORT held by done_ready=0 for 20 cycles, next kick two cycles after accept.
    done_ready = 1'b0;
    push_job(mk(4'd7, 10'h070, 10'h170, 10'h270));
    push_job(mk(4'd8, 10'h080, 10'h180, 10'h280));
    wait_done(200, n);
    chk("t3_done_valid", done_valid, 1);
    for (int i = 0; i < 20; i++) begin
      chk("t3_hold_valid", done_valid, 1);
      chk("t3_hold_tag", done_tag, 7);
      chk("t3_hold_error", done_error, 0);
      chk("t3_hold_no_kick", eng_kick_start, 0);
      tick();
    end
    done_ready = 1'b1;
    tick();
    chk("t3_accept_valid_low", done_valid, 0);
    chk("t3_accept_no_kick", eng_kick_start, 0);
    tick();
    chk("t3_next_kick", eng_kick_start, 1);
    chk("t3_next_base_a", eng_base_a, 10'h080);
    wait_done(200, n);
    chk("t3_second_done", done_valid, 1);
    chk("t3_second_tag", done_tag, 8);
    tick();

    // Reset in WAIT_DONE with two jobs queued: everything discarded silently.
    push_job(mk(4'd9,  10'h090, 10'h190, 10'h290));
    push_job(mk(4'd10, 10'h0a0, 10'h1a0, 10'h2a0));
    push_job(mk(4'd11, 10'h0b0, 10'h1b0, 10'h2b0));
    repeat (5) tick();
    chk("t4_pre_level", queue_level, 2);
    chk("t4_pre_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("t4_rst_level", queue_level, 0);
    chk("t4_rst_done_valid", done_valid, 0);
    chk("t4_rst_kick", eng_kick_start, 0);
    chk("t4_rst_job_ready", job_ready, 1);
    chk("t4_rst_busy", busy, 0);
    rst = 1'b0;
    seen = 0;
    repeat (100) begin
      if (done_valid || eng_kick_start) seen++;
      tick();
    end
    chk("t4_no_lost_records", 32'(seen), 0);

    // Engine accepts the kick but never drops ready.
    eng_hang = 1'b1;
    push_job(mk(4'd5, 10'h155, 10'h255, 10'h355));
    n = 0;
    while (!eng_kick_start && n < 20) begin
      tick();
      n++;
    end
    chk("t5_kick", eng_kick_start, 1);
`ifdef MATMUL_SCHED_TIMEOUT_EN
    wait_done(100, n);
    chk("t5_timeout_latency", 32'(n), 16);
    chk("t5_timeout_valid", done_valid, 1);
    chk("t5_timeout_error", done_error, 1);
    chk("t5_timeout_tag", done_tag, 5);
    tick();
    chk("t5_after_report", done_valid, 0);
    chk("t5_error_cleared", done_error, 0);
`else
    seen = 0;
    repeat (40) begin
      if (done_valid || done_error) seen++;
      tick();
    end
    chk("t6_no_report", 32'(seen), 0);
    chk("t6_still_busy", busy, 1);
    chk("t6_error_low", done_error, 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    eng_hang = 1'b0;
    tick();
    chk("end_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
